// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 padding of a 64-bit big-endian byte stream into 256-bit half-blocks.
// Optional feature macro SHA256_PADDER_EMPTY_MSG_EN: nbytes==0 on a last beat means zero data bytes.
module sha256_padder (
    input  logic         clk,
    input  logic         rst,
    input  logic         src_padder_data_val,
    input  logic [63:0]  src_padder_data,
    input  logic         src_padder_data_last,
    input  logic [3:0]   src_padder_data_nbytes,
    output logic         padder_src_rdy,
    output logic         padder_manager_data_val,
    output logic [255:0] padder_manager_data,
    output logic         padder_manager_data_last,
    input  logic         manager_padder_rdy
);
    localparam int unsigned SRC_DATA_W    = 64;
    localparam int unsigned SRC_BYTES_W   = 4;
    localparam int unsigned SHA_IF_DATA_W = 256;
    localparam int unsigned MSG_LEN_W     = 64;
    localparam int unsigned ASM_W         = SHA_IF_DATA_W - SRC_DATA_W;

    typedef enum logic [1:0] {
        ST_DATA,
        ST_PAD_MARK,
        ST_PAD_ZERO,
        ST_PAD_LEN
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              slot_idx_q;
    logic [MSG_LEN_W-1:0]    len_q;
    logic [ASM_W-1:0]        asm_q;

    logic                    stall;
    logic                    slot_we;
    logic                    slot_is_len;
    logic [SRC_DATA_W-1:0]   slot_val;
    logic [SRC_DATA_W-1:0]   beat_slot;
    logic [SRC_BYTES_W-1:0]  eff_bytes;
    logic                    beat_acc;

    // Number of message bytes carried by the current beat
    always_comb begin
        eff_bytes = SRC_BYTES_W'(8);
`ifdef SHA256_PADDER_EMPTY_MSG_EN
        if (src_padder_data_last && (src_padder_data_nbytes < SRC_BYTES_W'(8)))
            eff_bytes = src_padder_data_nbytes;
`else
        if (src_padder_data_last && (src_padder_data_nbytes != '0) &&
            (src_padder_data_nbytes < SRC_BYTES_W'(8)))
            eff_bytes = src_padder_data_nbytes;
`endif
    end

    // Keep valid bytes, place the 0x80 marker right after them, zero the rest
    always_comb begin
        beat_slot = '0;
        for (int i = 0; i < 8; i++) begin
            if (SRC_BYTES_W'(i) < eff_bytes)
                beat_slot[63-8*i -: 8] = src_padder_data[63-8*i -: 8];
            else if (SRC_BYTES_W'(i) == eff_bytes)
                beat_slot[63-8*i -: 8] = 8'h80;
        end
    end

    // Completing a word is only blocked by an output word that is not leaving this cycle
    assign stall          = (slot_idx_q[1:0] == 2'd3) && padder_manager_data_val && !manager_padder_rdy;
    assign padder_src_rdy = !rst && (state_q == ST_DATA) && !stall;
    assign beat_acc       = (state_q == ST_DATA) && src_padder_data_val && !stall;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_DATA;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        slot_we     = 1'b0;
        slot_is_len = 1'b0;
        slot_val    = '0;
        case (state_q)
            ST_DATA: begin
                if (src_padder_data_val && !stall) begin
                    slot_we  = 1'b1;
                    slot_val = beat_slot;
                    if (src_padder_data_last) begin
                        if (eff_bytes == SRC_BYTES_W'(8))
                            state_d = ST_PAD_MARK;
                        else if (slot_idx_q == 3'd6)
                            state_d = ST_PAD_LEN;
                        else
                            state_d = ST_PAD_ZERO;
                    end
                end
            end
            ST_PAD_MARK: begin
                if (!stall) begin
                    slot_we  = 1'b1;
                    slot_val = {8'h80, 56'h0};
                    state_d  = (slot_idx_q == 3'd6) ? ST_PAD_LEN : ST_PAD_ZERO;
                end
            end
            ST_PAD_ZERO: begin
                if (!stall) begin
                    slot_we = 1'b1;
                    if (slot_idx_q == 3'd6)
                        state_d = ST_PAD_LEN;
                end
            end
            ST_PAD_LEN: begin
                if (!stall) begin
                    slot_we     = 1'b1;
                    slot_is_len = 1'b1;
                    slot_val    = len_q;
                    state_d     = ST_DATA;
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    // Slot counter, length accumulator and word assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_idx_q <= '0;
            len_q      <= '0;
            asm_q      <= '0;
        end else begin
            if (slot_we) begin
                slot_idx_q <= slot_idx_q + 3'd1;
                case (slot_idx_q[1:0])
                    2'd0:    asm_q[191:128] <= slot_val;
                    2'd1:    asm_q[127:64]  <= slot_val;
                    2'd2:    asm_q[63:0]    <= slot_val;
                    default: ;
                endcase
            end
            if (slot_we && slot_is_len)
                len_q <= '0;
            else if (beat_acc)
                len_q <= len_q + MSG_LEN_W'({eff_bytes, 3'b000});
        end
    end

    // Output word register; drain and load may happen in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            padder_manager_data_val  <= 1'b0;
            padder_manager_data      <= '0;
            padder_manager_data_last <= 1'b0;
        end else begin
            if (padder_manager_data_val && manager_padder_rdy)
                padder_manager_data_val <= 1'b0;
            if (slot_we && (slot_idx_q[1:0] == 2'd3)) begin
                padder_manager_data_val  <= 1'b1;
                padder_manager_data      <= {asm_q, slot_val};
                padder_manager_data_last <= slot_is_len;
            end
        end
    end

endmodule
